// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard controller and the
// execute-stage operand muxes that consume its forwarding selects.
package hazard_pkg;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MULDIV_LAT_DEFAULT = 32;

    // M stage is the younger producer, so it wins over W; $zero never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        logic [1:0] sel;
        if ((src != REG_ZERO) && reg_write_m && (write_reg_m == src)) begin
            sel = FWD_M;
        end else if ((src != REG_ZERO) && reg_write_w && (write_reg_w == src)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RD;
        end
        return sel;
    endfunction

    function automatic logic reg_match(
        input logic [4:0] dst,
        input logic [4:0] a,
        input logic [4:0] b
    );
        return (dst != REG_ZERO) && ((dst == a) || (dst == b));
    endfunction

endpackage

// File: rtl/hazard_unit_muldiv_busy_ctr.sv
// Busy countdown for the multi-cycle mult/div unit: loads the latency on a
// start from idle and counts down to zero; starts while busy are ignored.
module muldiv_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] ZERO_C = '0;
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Countdown register: reload only when idle so a stray start cannot extend busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= ZERO_C;
        end else if (start && (cnt_r == ZERO_C)) begin
            cnt_r <= LAT_C;
        end else if (cnt_r != ZERO_C) begin
            cnt_r <= cnt_r - ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != ZERO_C);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, stall and
// flush controls, mult/div busy tracking and a stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        MulDivStartE,
    input  logic        MulDivUseD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        MulDivBusy,
    output logic [31:0] StallCount
);

    logic        busy_s;
    logic        lwstall_s;
    logic        branchstall_s;
    logic        mdstall_s;
    logic        stall_s;
    logic [31:0] stall_count_r;

    muldiv_busy_ctr #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_busy (
        .clk   (clk),
        .rst   (rst),
        .start (MulDivStartE),
        .busy  (busy_s)
    );

    // Forwarding selects and stall terms; everything is held inactive during reset.
    always_comb begin
        ForwardAE     = FWD_RD;
        ForwardBE     = FWD_RD;
        ForwardAD     = 1'b0;
        ForwardBD     = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        FlushE        = 1'b0;
        lwstall_s     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        branchstall_s = BranchD &&
                        ((RegWriteE && reg_match(WriteRegE, RsD, RtD)) ||
                         (MemtoRegM && reg_match(WriteRegM, RsD, RtD)));
        mdstall_s     = MulDivUseD && (MulDivStartE || busy_s);
        stall_s       = lwstall_s | branchstall_s | mdstall_s;
        if (rst) begin
            ForwardAE = FWD_RD;
            ForwardBE = FWD_RD;
            ForwardAD = 1'b0;
            ForwardBD = 1'b0;
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushE    = 1'b0;
        end else begin
            ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
            ForwardAD = (RsD != REG_ZERO) && RegWriteM && (WriteRegM == RsD);
            ForwardBD = (RtD != REG_ZERO) && RegWriteM && (WriteRegM == RtD);
            StallF    = stall_s;
            StallD    = stall_s;
            FlushE    = stall_s;
        end
    end

    // Stall-cycle performance counter; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= 32'd0;
        end else if (StallD) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign MulDivBusy = busy_s;
    assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with a 4-cycle mult/div latency.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic        BranchD, MulDivStartE, MulDivUseD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD, StallF, StallD, FlushE, MulDivBusy;
    logic [31:0] StallCount;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_unit #(.MULDIV_LAT(4), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MulDivStartE(MulDivStartE), .MulDivUseD(MulDivUseD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MulDivBusy(MulDivBusy), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
        WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
        MulDivStartE = 1'b0; MulDivUseD = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stall_chk(input string tag, input logic exp);
        chk({tag, "_stallf"}, {31'd0, StallF}, {31'd0, exp});
        chk({tag, "_stalld"}, {31'd0, StallD}, {31'd0, exp});
        chk({tag, "_flushe"}, {31'd0, FlushE}, {31'd0, exp});
    endtask

    initial begin
        // Reset with hazard-provoking inputs: everything must read zero.
        clear_inputs();
        rst = 1'b1;
        RsE = 5'd5; RegWriteM = 1'b1; WriteRegM = 5'd5;
        MemtoRegE = 1'b1; MulDivUseD = 1'b1; MulDivStartE = 1'b1;
        #1;
        chk("rst_fwdae", {30'd0, ForwardAE}, 32'd0);
        stall_chk("rst", 1'b0);
        chk("rst_busy", {31'd0, MulDivBusy}, 32'd0);
        chk("rst_cnt", StallCount, 32'd0);
        tick();
        clear_inputs();
        rst = 1'b0;
        tick();

        // Forward priority M over W, then W only, then $zero.
        WriteRegM = 5'd5; RegWriteM = 1'b1; WriteRegW = 5'd5; RegWriteW = 1'b1;
        RsE = 5'd5; RtE = 5'd5;
        #1;
        chk("fwd_ae_m", {30'd0, ForwardAE}, 32'd2);
        chk("fwd_be_m", {30'd0, ForwardBE}, 32'd2);
        RegWriteM = 1'b0;
        #1;
        chk("fwd_ae_w", {30'd0, ForwardAE}, 32'd1);
        RegWriteM = 1'b1; RsE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
        #1;
        chk("fwd_ae_zero", {30'd0, ForwardAE}, 32'd0);
        chk("fwd_be_none", {30'd0, ForwardBE}, 32'd0);
        RsD = 5'd0;
        #1;
        chk("fwd_ad_zero", {31'd0, ForwardAD}, 32'd0);
        clear_inputs();
        tick();

        // Load-use stall, then forwarding from M on the following cycle.
        MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8; RtD = 5'd9;
        RegWriteE = 1'b1; WriteRegE = 5'd8;
        #1;
        stall_chk("lw", 1'b1);
        tick();
        chk("lw_cnt", StallCount, 32'd1);
        clear_inputs();
        WriteRegM = 5'd8; RegWriteM = 1'b1; RsE = 5'd8; RtE = 5'd1; RsD = 5'd2; RtD = 5'd3;
        #1;
        chk("lw_fwd", {30'd0, ForwardAE}, 32'd2);
        stall_chk("lw_after", 1'b0);
        clear_inputs();
        tick();

        // Branch compare hazard on an ALU result in E, then forwarded from M.
        BranchD = 1'b1; RsD = 5'd3; RtD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd3;
        #1;
        stall_chk("br_e", 1'b1);
        tick();
        chk("br_cnt", StallCount, 32'd2);
        RegWriteE = 1'b0; WriteRegE = 5'd0;
        WriteRegM = 5'd3; RegWriteM = 1'b1; MemtoRegM = 1'b0;
        #1;
        stall_chk("br_m", 1'b0);
        chk("br_fwdad", {31'd0, ForwardAD}, 32'd1);
        chk("br_fwdbd", {31'd0, ForwardBD}, 32'd0);
        MemtoRegM = 1'b1; RsD = 5'd7; RtD = 5'd3;
        #1;
        chk("br_load_m", {31'd0, StallD}, 32'd1);
        chk("br_fwdbd_ld", {31'd0, ForwardBD}, 32'd1);
        clear_inputs();
        tick();

        // Clean counter before the mult/div run.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        tick();

        // Mult/div start plus dependent use: 5 stall cycles total.
        MulDivStartE = 1'b1; MulDivUseD = 1'b1;
        #1;
        chk("md_start_stall", {31'd0, StallD}, 32'd1);
        chk("md_start_busy", {31'd0, MulDivBusy}, 32'd0);
        tick();
        MulDivStartE = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("md_busy_%0d", i), {31'd0, MulDivBusy}, 32'd1);
            chk($sformatf("md_stall_%0d", i), {31'd0, StallD}, 32'd1);
            tick();
        end
        chk("md_busy_end", {31'd0, MulDivBusy}, 32'd0);
        chk("md_stall_end", {31'd0, StallD}, 32'd0);
        chk("md_cnt", StallCount, 32'd5);
        clear_inputs();
        tick();

        // Reset two cycles after a start: busy and counter clear at once.
        MulDivStartE = 1'b1; MulDivUseD = 1'b1;
        tick();
        MulDivStartE = 1'b0;
        tick();
        chk("rmid_busy_pre", {31'd0, MulDivBusy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_busy", {31'd0, MulDivBusy}, 32'd0);
        chk("rmid_cnt", StallCount, 32'd0);
        stall_chk("rmid", 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("rmid_post_stall", {31'd0, StallD}, 32'd0);
        tick();
        chk("rmid_post_busy", {31'd0, MulDivBusy}, 32'd0);
        chk("rmid_post_cnt", StallCount, 32'd0);
        clear_inputs();
        tick();

        // Second start while busy must not reload the countdown.
        MulDivStartE = 1'b1;
        tick();
        MulDivStartE = 1'b0;
        tick();
        MulDivStartE = 1'b1;
        tick();
        MulDivStartE = 1'b0;
        chk("ign_busy_3", {31'd0, MulDivBusy}, 32'd1);
        tick();
        chk("ign_busy_4", {31'd0, MulDivBusy}, 32'd1);
        tick();
        chk("ign_busy_5", {31'd0, MulDivBusy}, 32'd0);
        chk("ign_cnt", StallCount, 32'd0);

        // Counter wrap from all ones.
        force dut.stall_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.stall_count_r;
        #1;
        chk("wrap_preset", StallCount, 32'hFFFF_FFFF);
        MulDivUseD = 1'b1; MulDivStartE = 1'b1;
        tick();
        clear_inputs();
        chk("wrap_zero", StallCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
